// File: rtl/systolic_arr_ctrl_pkg.sv
// rtl/systolic_arr_ctrl_pkg.sv - shared types and constants for the systolic array front-end
// Purpose: array geometry, buffer depths, config byte indices, mode and run-state enums.
// Ports: none (package).
package arr_ctrl_pkg;

  localparam int LANES  = 16;
  localparam int DW     = 8;
  localparam int NCH    = 3;
  localparam int WDEPTH = 512;
  localparam int ADEPTH = 1024;

  // Width of all address / step / tile arithmetic; wide enough that
  // NCH*255*255 and LANES*L never wrap for any 8-bit config.
  localparam int AW  = 24;
  // Byte counter saturates at ADEPTH, so it needs one bit more than the index.
  localparam int CW  = $clog2(ADEPTH) + 1;
  localparam int WAB = $clog2(WDEPTH);
  localparam int AAB = $clog2(ADEPTH);

  localparam int CFG_IMG_W = 0;
  localparam int CFG_K     = 1;
  localparam int CFG_IMG_H = 2;
  localparam int CFG_NFILT = 3;

  typedef enum logic [1:0] {
    CFG   = 2'b00,
    WLOAD = 2'b01,
    ALOAD = 2'b10,
    RUN   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } run_state_t;

endpackage

// File: rtl/systolic_arr_ctrl_if.sv
// rtl/systolic_arr_ctrl_if.sv - control/load/stream bundle of the systolic array front-end
// Purpose: groups the byte-load inputs and the lane/strobe outputs.
// Signals: enable, mode, data_load, data_in (to controller);
//          aouts, wouts, saclk, fire, done (from controller).
// Modports: master drives the load side, slave is the controller.
interface systolic_arr_ctrl_if;
  import arr_ctrl_pkg::*;

  logic                enable;
  mode_t               mode;
  logic                data_load;
  logic [DW-1:0]       data_in;
  logic [LANES*DW-1:0] aouts;
  logic [LANES*DW-1:0] wouts;
  logic                saclk;
  logic                fire;
  logic                done;

  modport master (
    output enable, mode, data_load, data_in,
    input  aouts, wouts, saclk, fire, done
  );

  modport slave (
    input  enable, mode, data_load, data_in,
    output aouts, wouts, saclk, fire, done
  );

endinterface

// File: rtl/systolic_arr_ctrl_lane_addr.sv
// rtl/systolic_arr_ctrl_lane_addr.sv - per-lane skewed reduction index and im2col addresses
// Purpose: for lane LANE at (tile, step) computes k = step - LANE, its validity and
//          the activation / weight buffer addresses.
// Ports: step, tile, k_sz, kk, l_len, img_w, chan_sz, ow, nfilt in;
//        a_valid, w_valid, a_addr, w_addr out.
module arr_lane_addr
  import arr_ctrl_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic [AW-1:0] step,
  input  logic [AW-1:0] tile,
  input  logic [AW-1:0] k_sz,
  input  logic [AW-1:0] kk,
  input  logic [AW-1:0] l_len,
  input  logic [AW-1:0] img_w,
  input  logic [AW-1:0] chan_sz,
  input  logic [AW-1:0] ow,
  input  logic [AW-1:0] nfilt,
  output logic          a_valid,
  output logic          w_valid,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] w_addr
);

  localparam logic [AW-1:0] LANE_IDX = AW'(LANE);

  logic [AW:0]   diff;
  logic [AW-1:0] k, ch, rem, ky, kx, kk_div, k_div;
  logic          k_valid;

  // Borrow bit tells us the lane has not been reached by the skew yet.
  assign diff    = {1'b0, step} - {1'b0, LANE_IDX};
  assign k       = diff[AW-1:0];
  assign k_valid = !diff[AW] && (k < l_len);

  // Divisors are forced non-zero; K = 0 is rejected as a config before streaming.
  assign kk_div = (kk == '0) ? AW'(1) : kk;
  assign k_div  = (k_sz == '0) ? AW'(1) : k_sz;

  // k = ch*K*K + ky*K + kx
  assign ch  = k / kk_div;
  assign rem = k - ch * kk;
  assign ky  = rem / k_div;
  assign kx  = rem - ky * k_sz;

  assign a_addr  = ch * chan_sz + (tile + ky) * img_w + LANE_IDX + kx;
  assign w_addr  = LANE_IDX * l_len + k;
  assign a_valid = k_valid && (LANE_IDX < ow);
  assign w_valid = k_valid && (LANE_IDX < nfilt);

endmodule

// File: rtl/systolic_arr_ctrl.sv
// rtl/systolic_arr_ctrl.sv - front-end controller for a 16x16 output-stationary MAC array
// Purpose: loads a 4-byte config, weights and activations from a byte stream, then
//          im2col-streams skewed lanes with a step strobe, tile pulse and done flag.
// Ports: clk, rst (sync, active-high); bus (slave): enable, mode, data_load, data_in,
//        aouts, wouts, saclk, fire, done.
module systolic_arr_ctrl
  import arr_ctrl_pkg::*;
(
  input logic                clk,
  input logic                rst,
  systolic_arr_ctrl_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX = CW'(ADEPTH);

  logic [DW-1:0] cfg  [4];
  logic [DW-1:0] wbuf [WDEPTH];
  logic [DW-1:0] abuf [ADEPTH];

  mode_t               prev_mode;
  logic [CW-1:0]       cnt;
  run_state_t          run_state;
  logic [AW-1:0]       tile, step;
  logic [LANES*DW-1:0] aouts_q, wouts_q;
  logic                saclk_q, fire_q, done_q;

  logic                mode_chg, start, cfg_bad;
  logic [CW-1:0]       cnt_eff, cnt_inc;
  logic [AW-1:0]       img_w, img_h, k_sz, nfilt, kk, l_len, ow, oh, chan_sz, last_step;
  logic [AW-1:0]       cur_tile, cur_step;
  logic [LANES*DW-1:0] a_next, w_next;

  // A mode change takes effect in the same cycle: the byte written now lands at 0.
  assign mode_chg = (bus.mode != prev_mode);
  assign cnt_eff  = mode_chg ? '0 : cnt;
  assign cnt_inc  = (cnt_eff == CNT_MAX) ? cnt_eff : cnt_eff + CW'(1);

  assign img_w     = AW'(cfg[CFG_IMG_W]);
  assign k_sz      = AW'(cfg[CFG_K]);
  assign img_h     = AW'(cfg[CFG_IMG_H]);
  assign nfilt     = AW'(cfg[CFG_NFILT]);
  assign kk        = k_sz * k_sz;
  assign l_len     = kk * AW'(NCH);
  assign ow        = img_w - k_sz + AW'(1);
  assign oh        = img_h - k_sz + AW'(1);
  assign chan_sz   = img_h * img_w;
  assign last_step = l_len + AW'(2 * LANES - 2);

  assign cfg_bad = (k_sz == '0) || (k_sz > img_w) || (k_sz > img_h) ||
                   (nfilt > AW'(LANES)) ||
                   (nfilt * l_len > AW'(WDEPTH)) ||
                   (AW'(NCH) * chan_sz > AW'(ADEPTH));

  // The first run cycle emits step 0 of tile 0 directly, so the address
  // lanes see (0,0) rather than the stale counters.
  assign start    = mode_chg || (run_state == ST_IDLE);
  assign cur_tile = start ? '0 : tile;
  assign cur_step = start ? '0 : step;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic          a_ok, w_ok;
    logic [AW-1:0] a_addr, w_addr;

    arr_lane_addr #(.LANE(i)) u_addr (
      .step    (cur_step),
      .tile    (cur_tile),
      .k_sz    (k_sz),
      .kk      (kk),
      .l_len   (l_len),
      .img_w   (img_w),
      .chan_sz (chan_sz),
      .ow      (ow),
      .nfilt   (nfilt),
      .a_valid (a_ok),
      .w_valid (w_ok),
      .a_addr  (a_addr),
      .w_addr  (w_addr)
    );

    assign a_next[i*DW +: DW] = (a_ok && (a_addr < AW'(ADEPTH))) ? abuf[a_addr[AAB-1:0]] : '0;
    assign w_next[i*DW +: DW] = (w_ok && (w_addr < AW'(WDEPTH))) ? wbuf[w_addr[WAB-1:0]] : '0;
  end

  // Buffers are plain storage; reset intentionally leaves their contents alone.
  always_ff @(posedge clk) begin
    if (!rst && bus.enable && bus.data_load) begin
      if (bus.mode == WLOAD && cnt_eff < CW'(WDEPTH))
        wbuf[cnt_eff[WAB-1:0]] <= bus.data_in;
      if (bus.mode == ALOAD && cnt_eff < CW'(ADEPTH))
        abuf[cnt_eff[AAB-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg[CFG_IMG_W] <= DW'(16);
      cfg[CFG_K]     <= DW'(3);
      cfg[CFG_IMG_H] <= DW'(16);
      cfg[CFG_NFILT] <= DW'(16);
      cnt            <= '0;
      prev_mode      <= CFG;
      run_state      <= ST_IDLE;
      tile           <= '0;
      step           <= '0;
      aouts_q        <= '0;
      wouts_q        <= '0;
      saclk_q        <= 1'b0;
      fire_q         <= 1'b0;
      done_q         <= 1'b0;
    end else if (bus.enable) begin
      prev_mode <= bus.mode;
      cnt       <= cnt_eff;
      aouts_q   <= '0;
      wouts_q   <= '0;
      saclk_q   <= 1'b0;
      fire_q    <= 1'b0;
      if (mode_chg)
        done_q <= 1'b0;

      if (bus.mode != RUN) begin
        run_state <= ST_IDLE;
        tile      <= '0;
        step      <= '0;
        if (bus.data_load) begin
          cnt <= cnt_inc;
          if (bus.mode == CFG && cnt_eff < CW'(4))
            cfg[cnt_eff[1:0]] <= bus.data_in;
        end
      end else if (!start && run_state == ST_DONE) begin
        done_q <= 1'b1;
      end else if (start && cfg_bad) begin
        done_q    <= 1'b1;
        run_state <= ST_DONE;
      end else begin
        aouts_q <= a_next;
        wouts_q <= w_next;
        saclk_q <= 1'b1;
        if (cur_step == last_step) begin
          fire_q <= 1'b1;
          step   <= '0;
          if (cur_tile == oh - AW'(1)) begin
            run_state <= ST_DONE;
          end else begin
            tile      <= cur_tile + AW'(1);
            run_state <= ST_STREAM;
          end
        end else begin
          step      <= cur_step + AW'(1);
          tile      <= cur_tile;
          run_state <= ST_STREAM;
        end
      end
    end
  end

  assign bus.aouts = aouts_q;
  assign bus.wouts = wouts_q;
  assign bus.saclk = saclk_q;
  assign bus.fire  = fire_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_systolic_arr_ctrl.sv
// tb/tb_systolic_arr_ctrl.sv - self-checking bench for systolic_arr_ctrl
module tb_systolic_arr_ctrl;
  import arr_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_arr_ctrl_if bus();

  systolic_arr_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int n;
    int lane;
    int a;
    int w;
    int sc;
    int fi;
    int dn;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input mode_t m, input int b);
    bus.mode      = m;
    bus.data_load = 1'b1;
    bus.data_in   = DW'(b);
    tick();
  endtask

  // Expected lanes for the default config (W=H=16, K=3, NFILT=16) with
  // buffers holding idx%256; g counts steps from the start of the run.
  function automatic logic [LANES*DW-1:0] model_a(input int g);
    logic [LANES*DW-1:0] v;
    int y, s, k, ch, ky, kx;
    v = '0;
    y = g / 58;
    s = g % 58;
    for (int i = 0; i < LANES; i++) begin
      k = s - i;
      if (k >= 0 && k < 27 && i < 14) begin
        ch = k / 9;
        ky = (k % 9) / 3;
        kx = k % 3;
        v[i*DW +: DW] = DW'((ch * 256 + (y + ky) * 16 + i + kx) % 256);
      end
    end
    return v;
  endfunction

  function automatic logic [LANES*DW-1:0] model_w(input int g);
    logic [LANES*DW-1:0] v;
    int s, k;
    v = '0;
    s = g % 58;
    for (int i = 0; i < LANES; i++) begin
      k = s - i;
      if (k >= 0 && k < 27)
        v[i*DW +: DW] = DW'((i * 27 + k) % 256);
    end
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, fires, fire_bad, sacks, hi_nz, bad_cnt, g;
    logic [LANES*DW-1:0] av, wv;

    // {edge n after run start, lane, aouts lane, wouts lane, saclk, fire, done}
    tbl[0]  = '{1,   0,   0,   0, 1, 0, 0};
    tbl[1]  = '{1,   1,   0,   0, 1, 0, 0};
    tbl[2]  = '{2,   0,   1,   1, 1, 0, 0};
    tbl[3]  = '{2,   1,   1,  27, 1, 0, 0};
    tbl[4]  = '{27,  0,  34,  26, 1, 0, 0};
    tbl[5]  = '{28,  0,   0,   0, 1, 0, 0};
    tbl[6]  = '{28,  1,  35,  53, 1, 0, 0};
    tbl[7]  = '{40, 13,  47, 121, 1, 0, 0};
    tbl[8]  = '{42, 15,   0, 175, 1, 0, 0};
    tbl[9]  = '{58,  0,   0,   0, 1, 1, 0};
    tbl[10] = '{59,  0,  16,   0, 1, 0, 0};
    tbl[11] = '{60,  1,  17,  27, 1, 0, 0};
    tbl[12] = '{755, 0, 208,   0, 1, 0, 0};
    tbl[13] = '{781, 0, 242,  26, 1, 0, 0};
    tbl[14] = '{794, 13, 255, 121, 1, 0, 0};
    tbl[15] = '{812, 0,   0,   0, 1, 1, 0};
    tbl[16] = '{813, 0,   0,   0, 0, 0, 1};
    tbl[17] = '{830, 5,   0,   0, 0, 0, 1};

    rst           = 1'b1;
    bus.enable    = 1'b1;
    bus.mode      = CFG;
    bus.data_load = 1'b0;
    bus.data_in   = '0;
    tick();
    tick();
    check("rst_aouts", bus.aouts, '0);
    check("rst_wouts", bus.wouts, '0);
    check("rst_saclk", bus.saclk, 0);
    check("rst_fire",  bus.fire,  0);
    check("rst_done",  bus.done,  0);
    rst = 1'b0;

    send(CFG, 16);
    send(CFG, 3);
    send(CFG, 16);
    send(CFG, 16);
    for (int i = 0; i < 432; i++) send(WLOAD, i % 256);
    for (int i = 0; i < 768; i++) send(ALOAD, i % 256);
    bus.data_load = 1'b0;
    check("load_saclk", bus.saclk, 0);
    check("load_fire",  bus.fire,  0);
    check("load_aouts", bus.aouts, '0);

    // Full run of the default config
    bus.mode = RUN;
    idx = 0; fires = 0; fire_bad = 0; sacks = 0; hi_nz = 0;
    for (int n = 1; n <= 830; n++) begin
      tick();
      if (bus.fire) begin
        fires++;
        if (n % 58 != 0) fire_bad++;
      end
      if (bus.saclk) sacks++;
      if (bus.aouts[LANES*DW-1 -: 2*DW] != '0) hi_nz++;
      while (idx < NVEC && tbl[idx].n == n) begin
        av = bus.aouts;
        wv = bus.wouts;
        check($sformatf("run_a n=%0d l=%0d", n, tbl[idx].lane), av[tbl[idx].lane*DW +: DW], tbl[idx].a);
        check($sformatf("run_w n=%0d l=%0d", n, tbl[idx].lane), wv[tbl[idx].lane*DW +: DW], tbl[idx].w);
        check($sformatf("run_saclk n=%0d", n), bus.saclk, tbl[idx].sc);
        check($sformatf("run_fire n=%0d", n),  bus.fire,  tbl[idx].fi);
        check($sformatf("run_done n=%0d", n),  bus.done,  tbl[idx].dn);
        idx++;
      end
    end
    check("run_vectors_applied", idx, NVEC);
    check("run_fire_count", fires, 14);
    check("run_fire_spacing", fire_bad, 0);
    check("run_saclk_count", sacks, 812);
    check("run_lanes14_15_zero", hi_nz, 0);

    // Leaving run mode clears done; re-entering restarts at tile 0
    bus.mode = CFG;
    tick();
    check("modechg_done", bus.done, 0);
    bus.mode = RUN;
    tick();
    g = 0;
    while (g < 70) begin
      tick();
      g++;
    end
    check("frz_pre_a", bus.aouts, model_a(70));
    bus.enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("frz_a c=%0d", c), bus.aouts, model_a(70));
      check($sformatf("frz_w c=%0d", c), bus.wouts, model_w(70));
      check($sformatf("frz_saclk c=%0d", c), bus.saclk, 1);
    end
    bus.enable = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      g++;
      check($sformatf("resume_a g=%0d", g), bus.aouts, model_a(g));
      check($sformatf("resume_w g=%0d", g), bus.wouts, model_w(g));
    end

    // Reset mid-run aborts; next run begins at step 0 of tile 0
    while (g < 150) begin
      tick();
      g++;
    end
    check("pre_rst_a", bus.aouts, model_a(150));
    rst = 1'b1;
    tick();
    check("midrst_aouts", bus.aouts, '0);
    check("midrst_wouts", bus.wouts, '0);
    check("midrst_saclk", bus.saclk, 0);
    check("midrst_fire",  bus.fire,  0);
    check("midrst_done",  bus.done,  0);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("restart_a g=%0d", c), bus.aouts, model_a(c));
      check($sformatf("restart_w g=%0d", c), bus.wouts, model_w(c));
      check($sformatf("restart_saclk g=%0d", c), bus.saclk, 1);
    end

    // K = 17 exceeds the image: done immediately, no strobes
    send(CFG, 16);
    send(CFG, 17);
    send(CFG, 16);
    send(CFG, 16);
    bus.data_load = 1'b0;
    bus.mode      = RUN;
    tick();
    check("bad_done",  bus.done,  1);
    check("bad_saclk", bus.saclk, 0);
    check("bad_fire",  bus.fire,  0);
    bad_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.saclk || bus.fire) bad_cnt++;
    end
    check("bad_no_strobes", bad_cnt, 0);
    check("bad_done_held", bus.done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
